// File: rtl/top_cipher_iter_if.sv
// rtl/top_cipher_iter_if.sv - request/response handshake bundle for the iterative cipher core
interface top_cipher_iter_if #(
   parameter int DATAW = 32
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic             mode_i;
   logic [DATAW-1:0] ptext_i;
   logic [DATAW-1:0] key_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [DATAW-1:0] cipher_o;
   logic             busy_o;

   modport master (
      output in_valid_i, mode_i, ptext_i, key_i, out_ready_i,
      input  in_ready_o, out_valid_o, cipher_o, busy_o
   );

   modport slave (
      input  in_valid_i, mode_i, ptext_i, key_i, out_ready_i,
      output in_ready_o, out_valid_o, cipher_o, busy_o
   );
endinterface

// File: rtl/top_cipher_iter.sv
// rtl/top_cipher_iter.sv - iterative Feistel block cipher, one round per clock
module top_cipher_iter #(
   parameter int DATAW  = 32,
   parameter int ROUNDS = 16
) (
   input logic             clk_i,
   input logic             rst_i,
   top_cipher_iter_if.slave bus
);
   localparam int H = DATAW / 2;
   localparam logic [7:0] LAST = 8'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [H-1:0]     l_q, r_q, key_q;
   logic             mode_q;
   logic [7:0]       cnt_q;
   logic [DATAW-1:0] cipher_q;

   logic             accept;
   logic             last_round;
   logic [H-1:0]     rk, f_in, f_out, l_next, r_next;
   logic             unused_key;

   // Rotation by a variable amount below H: take the upper half of a doubled word.
   function automatic logic [H-1:0] rotl(input logic [H-1:0] x, input int unsigned amt);
      logic [2*H-1:0] wide;
      wide = {x, x} << amt;
      return wide[2*H-1:H];
   endfunction

   assign unused_key = ^bus.key_i[DATAW-1:H];

   assign accept     = (state_q == IDLE) && bus.in_valid_i;
   assign last_round = mode_q ? (cnt_q == 8'd0) : (cnt_q == LAST);

   assign rk    = rotl(key_q, 32'(cnt_q) % H) ^ H'(cnt_q);
   assign f_in  = mode_q ? l_q : r_q;
   assign f_out = (rotl(f_in, 3) + rk) ^ (f_in >> 1);

   // Decrypt walks the same network backwards, so the F input is the left half.
   always_comb begin
      l_next = r_q;
      r_next = l_q ^ f_out;
      if (mode_q) begin
         l_next = r_q ^ f_out;
         r_next = l_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      bus.in_ready_o  = 1'b0;
      bus.out_valid_o = 1'b0;
      bus.busy_o      = 1'b1;
      case (state_q)
         IDLE: begin
            bus.in_ready_o = 1'b1;
            bus.busy_o     = 1'b0;
            if (bus.in_valid_i) state_d = RUN;
         end
         RUN: begin
            if (last_round) state_d = DONE;
         end
         DONE: begin
            bus.out_valid_o = 1'b1;
            if (bus.out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The counter is held at its terminal value rather than stepped past it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         l_q      <= '0;
         r_q      <= '0;
         key_q    <= '0;
         mode_q   <= 1'b0;
         cnt_q    <= 8'd0;
         cipher_q <= '0;
      end else if (accept) begin
         l_q    <= bus.ptext_i[DATAW-1:H];
         r_q    <= bus.ptext_i[H-1:0];
         key_q  <= bus.key_i[H-1:0];
         mode_q <= bus.mode_i;
         cnt_q  <= bus.mode_i ? LAST : 8'd0;
      end else if (state_q == RUN) begin
         l_q <= l_next;
         r_q <= r_next;
         if (last_round)  cipher_q <= {l_next, r_next};
         else if (mode_q) cnt_q    <= cnt_q - 8'd1;
         else             cnt_q    <= cnt_q + 8'd1;
      end
   end

   assign bus.cipher_o = cipher_q;
endmodule

// File: tb/tb_top_cipher_iter.sv
// tb/tb_top_cipher_iter.sv - scoreboard bench for top_cipher_iter in three configurations
module tb_top_cipher_iter;
   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [31:0] val;
      int          due;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];
   logic pv[3] = '{1'b0, 1'b0, 1'b0};

   top_cipher_iter_if #(.DATAW(32)) ifa();
   top_cipher_iter_if #(.DATAW(32)) ifb();
   top_cipher_iter_if #(.DATAW(8))  ifc();

   top_cipher_iter #(.DATAW(32), .ROUNDS(1))   dut_a (.clk_i(clk), .rst_i(rst_a), .bus(ifa));
   top_cipher_iter #(.DATAW(32), .ROUNDS(16))  dut_b (.clk_i(clk), .rst_i(rst_b), .bus(ifb));
   top_cipher_iter #(.DATAW(8),  .ROUNDS(255)) dut_c (.clk_i(clk), .rst_i(rst_c), .bus(ifc));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference cipher straight from the round equations, on plain 64-bit integers.
   function automatic longint rotl_m(input longint x, input int s, input int h);
      longint mask = (64'd1 << h) - 1;
      if (s == 0) return x & mask;
      return ((x << s) | (x >> (h - s))) & mask;
   endfunction

   function automatic logic [31:0] model(input bit dec, input logic [31:0] blk,
                                         input logic [31:0] key, input int dw, input int rounds);
      int     h = dw / 2;
      longint mask = (64'd1 << h) - 1;
      longint l = (longint'(blk) >> h) & mask;
      longint r = longint'(blk) & mask;
      longint k = longint'(key) & mask;
      longint rk, fx, t;
      int     rnd;
      for (int step = 0; step < rounds; step++) begin
         rnd = dec ? rounds - 1 - step : step;
         rk  = (rotl_m(k, rnd % h, h) ^ longint'(rnd)) & mask;
         fx  = dec ? l : r;
         fx  = ((rotl_m(fx, 3, h) + rk) & mask) ^ (fx >> 1);
         if (!dec) begin t = r; r = l ^ fx; l = t; end
         else      begin t = l; l = r ^ fx; r = t; end
      end
      return 32'((l << h) | r);
   endfunction

   function automatic int rounds_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 16 : 255;
   endfunction

   function automatic logic rdy(input int d);
      return (d == 0) ? ifa.in_ready_o : (d == 1) ? ifb.in_ready_o : ifc.in_ready_o;
   endfunction

   function automatic logic vld(input int d);
      return (d == 0) ? ifa.out_valid_o : (d == 1) ? ifb.out_valid_o : ifc.out_valid_o;
   endfunction

   function automatic logic bsy(input int d);
      return (d == 0) ? ifa.busy_o : (d == 1) ? ifb.busy_o : ifc.busy_o;
   endfunction

   function automatic logic [31:0] cph(input int d);
      return (d == 0) ? ifa.cipher_o : (d == 1) ? ifb.cipher_o : {24'd0, ifc.cipher_o};
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q_a.size() : (d == 1) ? q_b.size() : q_c.size();
   endfunction

   function automatic exp_t pop_exp(input int d);
      if (d == 0) return q_a.pop_front();
      if (d == 1) return q_b.pop_front();
      return q_c.pop_front();
   endfunction

   task automatic push_exp(input int d, input exp_t e);
      case (d)
         0:       q_a.push_back(e);
         1:       q_b.push_back(e);
         default: q_c.push_back(e);
      endcase
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic drive(input int d, input logic v, input logic m,
                        input logic [31:0] p, input logic [31:0] k);
      case (d)
         0: begin ifa.in_valid_i = v; ifa.mode_i = m; ifa.ptext_i = p; ifa.key_i = k; end
         1: begin ifb.in_valid_i = v; ifb.mode_i = m; ifb.ptext_i = p; ifb.key_i = k; end
         default: begin
            ifc.in_valid_i = v; ifc.mode_i = m; ifc.ptext_i = p[7:0]; ifc.key_i = k[7:0];
         end
      endcase
   endtask

   // Present one request, then scramble the inputs so late changes cannot leak in.
   task automatic issue(input int d, input bit m, input logic [31:0] p,
                        input logic [31:0] k, input logic [31:0] want);
      int   guard = 0;
      exp_t e;
      @(negedge clk);
      while (!rdy(d) && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 1000) check($sformatf("dut%0d_ready_timeout", d), 32'(rdy(d)), 32'd1);
      drive(d, 1'b1, m, p, k);
      @(posedge clk);
      #1;
      e.val = want;
      e.due = cyc + rounds_of(d);
      push_exp(d, e);
      drive(d, 1'b0, 1'($urandom), $urandom, $urandom);
   endtask

   task automatic wait_drain(input int d);
      int guard = 0;
      while ((qsize(d) != 0) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) check($sformatf("dut%0d_drain_timeout", d), qsize(d), 0);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input int d);
      check($sformatf("dut%0d_rst_in_ready", d),  32'(rdy(d)), 32'd1);
      check($sformatf("dut%0d_rst_out_valid", d), 32'(vld(d)), 32'd0);
      check($sformatf("dut%0d_rst_busy", d),      32'(bsy(d)), 32'd0);
      check($sformatf("dut%0d_rst_cipher", d),    cph(d),      32'd0);
   endtask

   // Scoreboard monitor: every rising out_valid_o must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         if (vld(d) && !pv[d]) begin
            if (qsize(d) == 0) begin
               checks++;
               errors++;
               $display("FAIL dut%0d_unexpected_valid: got cipher %h, expected no result", d, cph(d));
            end else begin
               e = pop_exp(d);
               check($sformatf("dut%0d_cipher", d), cph(d), e.val);
               check($sformatf("dut%0d_latency", d), 32'(cyc), 32'(e.due));
            end
         end
         pv[d] = vld(d);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion, expected finish before 90000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] p, k, c;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
      ifa.out_ready_i = 1'b1; ifb.out_ready_i = 1'b1; ifc.out_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) check_reset_outputs(d);
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // Single-round directed vectors and a round trip.
      issue(0, 1'b0, 32'h0001_0000, 32'd0, 32'h0000_0001);
      issue(0, 1'b0, 32'h0000_0001, 32'd0, 32'h0001_0008);
      issue(0, 1'b1, 32'h0001_0008, 32'd0, 32'h0000_0001);
      for (int i = 0; i < 6; i++) begin
         p = $urandom; k = $urandom;
         c = model(1'b0, p, k, 32, 1);
         issue(0, 1'b0, p, k, c);
         issue(0, 1'b1, c, k, p);
      end
      wait_drain(0);
      check("dut0_cipher_hold_idle", cph(0), p);

      // Sixteen-round random round trips.
      for (int i = 0; i < 1000; i++) begin
         p = $urandom; k = $urandom;
         c = model(1'b0, p, k, 32, 16);
         issue(1, 1'b0, p, k, c);
         issue(1, 1'b1, c, k, p);
      end
      wait_drain(1);

      // Backpressure in DONE while the request side keeps poking.
      ifb.out_ready_i = 1'b0;
      p = $urandom; k = $urandom;
      c = model(1'b0, p, k, 32, 16);
      issue(1, 1'b0, p, k, c);
      for (int g = 0; g < 100 && !ifb.out_valid_o; g++) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_cipher", ifb.cipher_o, c);
         check("bp_out_valid", 32'(ifb.out_valid_o), 32'd1);
         check("bp_in_ready", 32'(ifb.in_ready_o), 32'd0);
         ifb.in_valid_i = 1'($urandom);
         ifb.ptext_i    = $urandom;
         ifb.mode_i     = 1'($urandom);
      end
      ifb.in_valid_i  = 1'b0;
      ifb.out_ready_i = 1'b1;
      wait_drain(1);
      repeat (20) @(negedge clk);
      check("bp_no_second_accept", 32'(ifb.busy_o), 32'd0);
      check("bp_cipher_hold_idle", ifb.cipher_o, c);

      // Reset mid-operation discards the in-flight block.
      p = $urandom; k = $urandom;
      issue(1, 1'b0, p, k, model(1'b0, p, k, 32, 16));
      repeat (5) @(posedge clk);
      #1;
      check("run_busy", 32'(ifb.busy_o), 32'd1);
      check("run_in_ready", 32'(ifb.in_ready_o), 32'd0);
      rst_b = 1'b1;
      #1;
      check_reset_outputs(1);
      void'(q_b.pop_back());
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      repeat (40) @(negedge clk);
      p = $urandom; k = $urandom;
      c = model(1'b0, p, k, 32, 16);
      issue(1, 1'b0, p, k, c);
      issue(1, 1'b1, c, k, p);
      wait_drain(1);

      // Narrow block, maximum round count.
      for (int i = 0; i < 8; i++) begin
         p = {24'd0, 8'($urandom)}; k = {24'd0, 8'($urandom)};
         c = model(1'b0, p, k, 8, 255);
         issue(2, 1'b0, p, k, c);
         issue(2, 1'b1, c, k, p);
      end
      wait_drain(2);

      for (int d = 0; d < 3; d++) check($sformatf("dut%0d_queue_empty", d), qsize(d), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
